// File: rtl/loopback_smoke_rpc_pkg.sv
// Shared types and constants for the loopback smoke-test RPC endpoint core.
// The response struct is sized at the default data width.
package loopback_smoke_rpc_pkg;

  localparam int ID_W_DEF   = 64;
  localparam int DATA_W_DEF = 32;

  localparam int unsigned METHOD_INC = 0;

  typedef enum logic [2:0] {
    ST_UNBOUND,
    ST_DEFINE,
    ST_IDLE,
    ST_RESP,
    ST_FAULT
  } state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] retval;
    logic                  has_retval;
    logic                  error;
  } rsp_t;

endpackage

// File: rtl/loopback_smoke_rpc_core_if.sv
// Request/response valid-ready channels between an RPC caller (master) and the endpoint core (slave).
interface loopback_smoke_rpc_core_if #(
  parameter int ID_W   = 64,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   req_method_id;
  logic [DATA_W-1:0] req_param;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_retval;
  logic              rsp_has_retval;
  logic              rsp_error;

  modport master (
    output req_valid, req_method_id, req_param, rsp_ready,
    input  req_ready, rsp_valid, rsp_retval, rsp_has_retval, rsp_error
  );

  modport slave (
    input  req_valid, req_method_id, req_param, rsp_ready,
    output req_ready, rsp_valid, rsp_retval, rsp_has_retval, rsp_error
  );
endinterface

// File: rtl/loopback_smoke_rpc_dispatch.sv
// Combinational method decode/execute: maps (method id, argument) to a response.
module loopback_smoke_rpc_dispatch
  import loopback_smoke_rpc_pkg::*;
#(
  parameter int ID_W   = ID_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [ID_W-1:0]   method_id_i,
  input  logic [DATA_W-1:0] param_i,
  output rsp_t              rsp_o
);

  // Full-width id compare: any nonzero bit anywhere makes the call unknown.
  always_comb begin
    rsp_o = '0;
    if (method_id_i == ID_W'(METHOD_INC)) begin
      rsp_o.retval     = DATA_W_DEF'(param_i + DATA_W'(1));
      rsp_o.has_retval = 1'b1;
    end else begin
      rsp_o.error = 1'b1;
    end
  end

endmodule

// File: rtl/loopback_smoke_rpc_core.sv
// RPC endpoint core: announces its instance once after reset, then serves one
// blocking call at a time with registered responses.
module loopback_smoke_rpc_core
  import loopback_smoke_rpc_pkg::*;
#(
  parameter int ID_W    = ID_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int INST_ID = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ep_present,
  output logic        define_valid,
  output logic [7:0]  define_inst_id,
  output logic        fault,
  output logic [15:0] inc_count,
  output logic [15:0] err_count,
  loopback_smoke_rpc_core_if.slave rpc
);

  state_e      state_q;
  logic        define_valid_q;
  logic        fault_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  rsp_t        rsp_q;
  rsp_t        rsp_d;
  logic [15:0] inc_count_q;
  logic [15:0] err_count_q;

  loopback_smoke_rpc_dispatch #(
    .ID_W   (ID_W),
    .DATA_W (DATA_W)
  ) u_dispatch (
    .method_id_i (rpc.req_method_id),
    .param_i     (rpc.req_param),
    .rsp_o       (rsp_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_UNBOUND;
      define_valid_q <= 1'b0;
      fault_q        <= 1'b0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_q          <= '0;
      inc_count_q    <= '0;
      err_count_q    <= '0;
    end else begin
      define_valid_q <= 1'b0;
      unique case (state_q)
        ST_UNBOUND: begin
          if (ep_present) begin
            state_q        <= ST_DEFINE;
            define_valid_q <= 1'b1;
          end else begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end
        end
        ST_DEFINE: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        ST_IDLE: begin
          if (rpc.req_valid && req_ready_q) begin
            state_q     <= ST_RESP;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_q       <= rsp_d;
            // Counters saturate rather than wrap.
            if (rsp_d.error) begin
              if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
            end else begin
              if (inc_count_q != 16'hFFFF) inc_count_q <= inc_count_q + 16'd1;
            end
          end
        end
        ST_RESP: begin
          if (rpc.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        ST_FAULT: begin
          fault_q     <= 1'b1;
          req_ready_q <= 1'b0;
        end
        default: state_q <= ST_UNBOUND;
      endcase
    end
  end

  assign define_valid       = define_valid_q;
  assign define_inst_id     = 8'(INST_ID);
  assign fault              = fault_q;
  assign inc_count          = inc_count_q;
  assign err_count          = err_count_q;
  assign rpc.req_ready      = req_ready_q;
  assign rpc.rsp_valid      = rsp_valid_q;
  assign rpc.rsp_retval     = DATA_W'(rsp_q.retval);
  assign rpc.rsp_has_retval = rsp_q.has_retval;
  assign rpc.rsp_error      = rsp_q.error;

endmodule

// File: tb/tb_loopback_smoke_rpc_core.sv
// Bench for the RPC endpoint core: directed bring-up/call scenarios plus random
// calls checked against a call-level reference model.
module tb_loopback_smoke_rpc_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        ep_present;
  logic        define_valid;
  logic [7:0]  define_inst_id;
  logic        fault;
  logic [15:0] inc_count;
  logic [15:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;
  int m_inc   = 0;
  int m_err   = 0;

  loopback_smoke_rpc_core_if #(.ID_W(64), .DATA_W(32)) rpc_if ();

  loopback_smoke_rpc_core #(
    .ID_W    (64),
    .DATA_W  (32),
    .INST_ID (0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ep_present     (ep_present),
    .define_valid   (define_valid),
    .define_inst_id (define_inst_id),
    .fault          (fault),
    .inc_count      (inc_count),
    .err_count      (err_count),
    .rpc            (rpc_if)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset, check reset values, then release and watch the bring-up.
  task automatic bring_up(input bit ep);
    int pulses;
    reset               = 1'b1;
    ep_present          = ep;
    rpc_if.req_valid    = 1'b0;
    rpc_if.rsp_ready    = 1'b0;
    rpc_if.req_method_id = '0;
    rpc_if.req_param    = '0;
    repeat (3) tick();
    check_val("rst_define_valid", define_valid, 0);
    check_val("rst_inst_id", define_inst_id, 0);
    check_val("rst_fault", fault, 0);
    check_val("rst_req_ready", rpc_if.req_ready, 0);
    check_val("rst_rsp_valid", rpc_if.rsp_valid, 0);
    check_val("rst_counts", {inc_count, err_count}, 0);
    m_inc = 0;
    m_err = 0;
    reset = 1'b0;
    tick();
    check_val("define_timing", define_valid, ep);
    pulses = define_valid ? 1 : 0;
    repeat (7) begin
      tick();
      if (define_valid) begin
        pulses++;
        check_val("define_inst_id", define_inst_id, 0);
      end
    end
    check_val("define_pulses", pulses, ep ? 1 : 0);
    check_val("bringup_fault", fault, ep ? 0 : 1);
    check_val("bringup_req_ready", rpc_if.req_ready, ep ? 1 : 0);
  endtask

  // One complete call; hold = cycles the consumer stalls before taking the response.
  task automatic do_call(input logic [63:0] id, input logic [31:0] prm, input int hold);
    logic [31:0] e_ret;
    logic        e_has;
    logic        e_err;
    int          waited;
    rpc_if.req_valid     = 1'b1;
    rpc_if.req_method_id = id;
    rpc_if.req_param     = prm;
    rpc_if.rsp_ready     = (hold == 0);
    waited = 0;
    while (!rpc_if.req_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!rpc_if.req_ready) begin
      check_val("accept_timeout", 0, 1);
      rpc_if.req_valid = 1'b0;
      rpc_if.rsp_ready = 1'b0;
      return;
    end
    tick();
    rpc_if.req_valid     = 1'b0;
    rpc_if.req_method_id = {$urandom, $urandom};
    rpc_if.req_param     = $urandom;
    if (id == 64'd0) begin
      e_ret = prm + 32'd1;
      e_has = 1'b1;
      e_err = 1'b0;
      m_inc = (m_inc < 65535) ? m_inc + 1 : 65535;
    end else begin
      e_ret = 32'd0;
      e_has = 1'b0;
      e_err = 1'b1;
      m_err = (m_err < 65535) ? m_err + 1 : 65535;
    end
    check_val("rsp_valid", rpc_if.rsp_valid, 1);
    check_val("rsp_retval", rpc_if.rsp_retval, e_ret);
    check_val("rsp_has_retval", rpc_if.rsp_has_retval, e_has);
    check_val("rsp_error", rpc_if.rsp_error, e_err);
    check_val("busy_req_ready", rpc_if.req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_val("stall_rsp_valid", rpc_if.rsp_valid, 1);
      check_val("stall_rsp", {rpc_if.rsp_retval, rpc_if.rsp_has_retval, rpc_if.rsp_error},
                {e_ret, e_has, e_err});
      check_val("stall_req_ready", rpc_if.req_ready, 0);
    end
    rpc_if.rsp_ready = 1'b1;
    tick();
    rpc_if.rsp_ready = 1'b0;
    check_val("post_rsp_valid", rpc_if.rsp_valid, 0);
    check_val("post_req_ready", rpc_if.req_ready, 1);
    check_val("inc_count", inc_count, m_inc);
    check_val("err_count", err_count, m_err);
  endtask

  initial begin
    logic [63:0] rid;
    logic [31:0] rprm;
    int          ready_seen;
    int          waited;
    int          pulses;

    // No endpoint: fault, and requests are never accepted.
    bring_up(1'b0);
    rpc_if.req_valid = 1'b1;
    ready_seen = 0;
    repeat (100) begin
      tick();
      if (rpc_if.req_ready) ready_seen++;
    end
    check_val("fault_ready_seen", ready_seen, 0);
    check_val("fault_sticky", fault, 1);
    check_val("fault_rsp_valid", rpc_if.rsp_valid, 0);

    bring_up(1'b1);

    do_call(64'd0, 32'd5, 0);
    do_call(64'd0, 32'h7FFF_FFFF, 0);
    do_call(64'd0, 32'hFFFF_FFFF, 0);
    check_val("inc_count_three", inc_count, 3);
    do_call(64'd7, 32'h1234_5678, 0);
    do_call(64'h8000_0000_0000_0000, 32'd0, 1);
    do_call(64'd0, 32'd41, 10);
    do_call(64'd0, 32'd99, 0);

    for (int n = 0; n < 40; n++) begin
      rid = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rprm = 32'd0;
        1:       rprm = 32'hFFFF_FFFF;
        2:       rprm = 32'h7FFF_FFFF;
        default: rprm = $urandom;
      endcase
      do_call(rid, rprm, $urandom_range(0, 3));
    end

    // Reset while a response is pending.
    rpc_if.req_valid     = 1'b1;
    rpc_if.req_method_id = 64'd0;
    rpc_if.req_param     = 32'd10;
    rpc_if.rsp_ready     = 1'b0;
    waited = 0;
    while (!rpc_if.req_ready && waited < 20) begin
      tick();
      waited++;
    end
    check_val("midrst_accept_ready", rpc_if.req_ready, 1);
    tick();
    rpc_if.req_valid = 1'b0;
    check_val("midrst_in_resp", rpc_if.rsp_valid, 1);
    reset = 1'b1;
    tick();
    check_val("midrst_rsp_valid", rpc_if.rsp_valid, 0);
    check_val("midrst_counts", {inc_count, err_count}, 0);
    m_inc = 0;
    m_err = 0;
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      tick();
      if (define_valid) pulses++;
    end
    check_val("midrst_define_pulses", pulses, 1);
    do_call(64'd0, 32'd1, 0);
    do_call(64'd3, 32'd1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/loopback_smoke_rpc_core.md
# loopback_smoke_rpc_core

Hardware RPC endpoint core for the loopback smoke test. It registers one interface instance with its endpoint after reset. It then accepts blocking method invocations over a valid/ready request channel and returns results over a valid/ready response channel. Method id 0 (`inc`) returns its 32-bit argument plus one; any other method id returns an error response.

## Interface
Parameters:
- `ID_W`, 64: method-id width (matches `longint` id).
- `DATA_W`, 32: argument/return width.
- `INST_ID`, 0: interface-instance id reported at definition.

Ports:
- `clock`  in  1  sole clock; everything on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ep_present`  in  1  default endpoint exists; sampled once after reset.
- `define_valid`  out  1  one-cycle pulse announcing the instance definition.
- `define_inst_id`  out  8  equals `INST_ID`; valid with `define_valid`.
- `fault`  out  1  no endpoint at bring-up; sticky until reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  core can accept a request.
- `req_method_id`  in  ID_W  method id.
- `req_param`  in  DATA_W  argument 0.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_retval`  out  DATA_W  return value.
- `rsp_has_retval`  out  1  1 = value returned; 0 = null retval.
- `rsp_error`  out  1  unknown method id.
- `inc_count`  out  16  completed `inc` calls; saturating.
- `err_count`  out  16  unknown-id calls; saturating.

## Operation
- FSM states: UNBOUND, DEFINE, IDLE, RESP, FAULT. Reset enters UNBOUND.
- UNBOUND: samples `ep_present` in the first cycle after `reset` deasserts.
  - 1 -> DEFINE.
  - 0 -> FAULT.
- DEFINE: `define_valid`=1 for exactly one cycle, then -> IDLE.
- FAULT: `fault`=1 and `req_ready`=0 forever; only `reset` leaves it.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, the core captures id and param, computes the result into output registers, and moves to RESP.
- Method id 0 (`inc`):
  - `rsp_retval` = `req_param` + 1, modulo 2^DATA_W; overflow wraps silently.
  - `rsp_has_retval`=1, `rsp_error`=0.
  - `inc_count` increments.
- Any other id (full ID_W compare):
  - `rsp_retval`=0, `rsp_has_retval`=0, `rsp_error`=1.
  - `err_count` increments.
- Both counters saturate at 0xFFFF.
- RESP: `rsp_valid`=1. Response outputs are held stable until `rsp_valid && rsp_ready`, then -> IDLE.
- `req_ready`=0 outside IDLE. Requests are never queued or dropped; the producer must hold them.

## Timing
- Reset values: all outputs 0, except `define_inst_id` = `INST_ID` (constant); counters 0.
- Bring-up: reset deasserts at edge R. `define_valid` is high during cycle R+1..R+2, i.e. registered the edge after the sample; in FAULT, `fault` rises one edge after the sample.
- Latency: request accepted at edge N gives `rsp_valid`=1 from edge N until the handshake edge.
- Zero-wait consumer: response handshake at edge N+1; next request accepted no earlier than edge N+2.
- Throughput: max one call per 2 cycles; the core is blocking with one outstanding call.
- `rsp_ready` may be high before `rsp_valid`; the handshake completes on the first edge where both are high.
- `reset` mid-call aborts the call: response lost, counters cleared, back to UNBOUND.

## Structure
- Package `loopback_smoke_rpc_pkg` holds:
  - FSM state enum.
  - `METHOD_INC` = 0.
  - Default widths.
  - Response struct: retval, has_retval, error.
- Sub-module `loopback_smoke_rpc_dispatch`: purely combinational method decode/execute. Maps (id, param) to the response struct; the core registers its output.

## Test plan
- Bring-up with `ep_present`=1 -> exactly one `define_valid` pulse with `define_inst_id`=0, then `req_ready`=1, `fault`=0.
- Bring-up with `ep_present`=0 -> `fault`=1, `req_ready` stays 0 for 100 cycles despite `req_valid`.
- id 0, param 5 -> retval 6, has_retval 1, error 0, one cycle after accept. Repeat with 0x7FFFFFFF -> 0x80000000 and 0xFFFFFFFF -> 0, `inc_count`=3.
- id 7 -> error 1, has_retval 0, retval 0, `err_count`=1, `inc_count` unchanged.
- Hold `rsp_ready`=0 for 10 cycles -> response stable, `req_ready`=0. Then release -> handshake, and a back-to-back request is accepted on the following edge.
- Assert `reset` while in RESP -> `rsp_valid` and counters 0 next cycle, and a fresh `define_valid` pulse follows.
